// File: rtl/maze_pellet_view.sv
// Pipelined tile-maze renderer with per-tile pellet state, an eat request/ack port and an init sweep.
// Optional macro POWER_PELLET_EN adds larger power pellets drawn in POWER_COLOR.
module maze_pellet_view #(
  parameter int                    ROWS         = 8,
  parameter int                    COLS         = 8,
  parameter int                    TILE_PX      = 60,
  parameter int                    PELLET_PX    = 8,
  parameter logic [ROWS*COLS-1:0]  PATH_MAP     = 64'h007E_4242_7E12_1E00,
  parameter logic [11:0]           WALL_COLOR   = 12'h8AF,
  parameter logic [11:0]           PATH_COLOR   = 12'h000,
  parameter logic [11:0]           PELLET_COLOR = 12'hFFF,
  parameter logic [ROWS*COLS-1:0]  POWER_MAP    = 64'h0040_0000_0000_0002,
  parameter logic [11:0]           POWER_COLOR  = 12'hFA0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_valid,
  input  logic [9:0]                     p_row,
  input  logic [9:0]                     p_col,
  output logic                           color_valid,
  output logic [11:0]                    color_data,
  input  logic                           eat_req,
  input  logic [9:0]                     eat_row,
  input  logic [9:0]                     eat_col,
  output logic                           eat_ack,
  output logic                           eat_hit,
  output logic                           eat_power,
  input  logic                           refill,
  output logic                           busy,
  output logic [$clog2(ROWS*COLS+1)-1:0] pellets_left,
  output logic                           all_eaten
);
  localparam int NT = ROWS * COLS;
  localparam int IW = (NT > 1) ? $clog2(NT) : 1;
  localparam int CW = $clog2(NT + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [9:0]    TILE_W   = 10'(TILE_PX);
  localparam logic [9:0]    ROW_MAX  = 10'(ROWS - 1);
  localparam logic [9:0]    COL_MAX  = 10'(COLS - 1);
  localparam logic [9:0]    ROWS_W   = 10'(ROWS);
  localparam logic [9:0]    COLS_W   = 10'(COLS);
  localparam logic [IW-1:0] COLS_I   = IW'(COLS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NT - 1);
  localparam logic [9:0]    PEL_LO   = 10'((TILE_PX - PELLET_PX) / 2);
  localparam logic [9:0]    PEL_HI   = 10'((TILE_PX - PELLET_PX) / 2 + PELLET_PX);
`ifdef POWER_PELLET_EN
  localparam logic [9:0]    PWR_LO   = 10'((TILE_PX - 2 * PELLET_PX) / 2);
  localparam logic [9:0]    PWR_HI   = 10'((TILE_PX - 2 * PELLET_PX) / 2 + 2 * PELLET_PX);
`endif

  typedef enum logic {ST_INIT = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NT-1:0]   pellet_q, pellet_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ack_q, ack_d, hit_q, hit_d, pow_q, pow_d;
  logic            s1_valid_q, s1_valid_d;
  logic [RW-1:0]   s1_row_q, s1_row_d;
  logic [KW-1:0]   s1_col_q, s1_col_d;
  logic [9:0]      s1_orow_q, s1_orow_d, s1_ocol_q, s1_ocol_d;
  logic            cv_q, cv_d;
  logic [11:0]     cd_q, cd_d;
  logic [9:0]      row_tile_s, col_tile_s;
  logic [IW-1:0]   pix_idx_s, eat_idx_s;
  logic            eat_in_range_s, in_small_s, pel_on_s;
`ifdef POWER_PELLET_EN
  logic            in_big_s;
`else
  logic            unused_power_s;
  assign unused_power_s = ^{POWER_MAP, POWER_COLOR};
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = (!refill && idx_q == LAST_IDX) ? ST_IDLE : ST_INIT;
      ST_IDLE: state_d = refill ? ST_INIT : ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    busy      = (state_q == ST_INIT);
    all_eaten = (state_q == ST_IDLE) && (count_q == '0);
  end

  // Sweep, eat handling and stage-1 tile/offset split.
  always_comb begin
    idx_d          = idx_q;
    pellet_d       = pellet_q;
    count_d        = count_q;
    ack_d          = 1'b0;
    hit_d          = 1'b0;
    pow_d          = 1'b0;
    eat_in_range_s = (eat_row < ROWS_W) && (eat_col < COLS_W);
    eat_idx_s      = IW'(eat_row) * COLS_I + IW'(eat_col);
    if (refill) begin
      idx_d   = '0;
      count_d = '0;
    end else if (state_q == ST_INIT) begin
      pellet_d[idx_q] = PATH_MAP[idx_q];
      count_d         = count_q + CW'(PATH_MAP[idx_q]);
      idx_d           = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
    end else if (eat_req) begin
      ack_d = 1'b1;
      if (eat_in_range_s && pellet_q[eat_idx_s]) begin
        pellet_d[eat_idx_s] = 1'b0;
        count_d             = count_q - CW'(1);
        hit_d               = 1'b1;
`ifdef POWER_PELLET_EN
        pow_d               = POWER_MAP[eat_idx_s];
`endif
      end else begin
        hit_d = 1'b0;
      end
    end else begin
      ack_d = 1'b0;
    end

    row_tile_s = p_row / TILE_W;
    col_tile_s = p_col / TILE_W;
    if (row_tile_s > ROW_MAX) row_tile_s = ROW_MAX;
    else                      row_tile_s = row_tile_s;
    if (col_tile_s > COL_MAX) col_tile_s = COL_MAX;
    else                      col_tile_s = col_tile_s;
    s1_valid_d = pix_valid;
    s1_row_d   = row_tile_s[RW-1:0];
    s1_col_d   = col_tile_s[KW-1:0];
    s1_orow_d  = p_row - row_tile_s * TILE_W;
    s1_ocol_d  = p_col - col_tile_s * TILE_W;
  end

  // Stage 2 reads pellet_q, so an eat landing this cycle is not yet visible.
  always_comb begin
    pix_idx_s  = IW'(s1_row_q) * COLS_I + IW'(s1_col_q);
    in_small_s = (s1_orow_q >= PEL_LO) && (s1_orow_q < PEL_HI) &&
                 (s1_ocol_q >= PEL_LO) && (s1_ocol_q < PEL_HI);
    pel_on_s   = pellet_q[pix_idx_s] && (state_q == ST_IDLE);
`ifdef POWER_PELLET_EN
    in_big_s   = (s1_orow_q >= PWR_LO) && (s1_orow_q < PWR_HI) &&
                 (s1_ocol_q >= PWR_LO) && (s1_ocol_q < PWR_HI);
`endif
    cv_d = s1_valid_q;
    if (!PATH_MAP[pix_idx_s])                                       cd_d = WALL_COLOR;
`ifdef POWER_PELLET_EN
    else if (pel_on_s && POWER_MAP[pix_idx_s] && in_big_s)          cd_d = POWER_COLOR;
    else if (pel_on_s && !POWER_MAP[pix_idx_s] && in_small_s)       cd_d = PELLET_COLOR;
`else
    else if (pel_on_s && in_small_s)                                cd_d = PELLET_COLOR;
`endif
    else                                                            cd_d = PATH_COLOR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      pellet_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      hit_q      <= 1'b0;
      pow_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_orow_q  <= 10'd0;
      s1_ocol_q  <= 10'd0;
      cv_q       <= 1'b0;
      cd_q       <= 12'h000;
    end else begin
      idx_q      <= idx_d;
      pellet_q   <= pellet_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      hit_q      <= hit_d;
      pow_q      <= pow_d;
      s1_valid_q <= s1_valid_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      s1_orow_q  <= s1_orow_d;
      s1_ocol_q  <= s1_ocol_d;
      cv_q       <= cv_d;
      cd_q       <= cd_d;
    end
  end

  assign color_valid  = cv_q;
  assign color_data   = cd_q;
  assign eat_ack      = ack_q;
  assign eat_hit      = hit_q;
  assign eat_power    = pow_q;
  assign pellets_left = count_q;
endmodule

// File: tb/tb_maze_pellet_view.sv
// Randomised + directed bench for maze_pellet_view (default build) against a tile-level reference model.
module tb_maze_pellet_view;
  localparam logic [63:0] MAP = 64'h007E_4242_7E12_1E00;

  logic clk = 1'b0;
  logic reset = 1'b1, pix_valid = 1'b0, eat_req = 1'b0, refill = 1'b0;
  logic [9:0] p_row = 10'd0, p_col = 10'd0, eat_row = 10'd0, eat_col = 10'd0;
  logic color_valid, eat_ack, eat_hit, eat_power, busy, all_eaten;
  logic [11:0] color_data;
  logic [6:0] pellets_left;

  int n_cmp = 0;
  int n_fail = 0;

  maze_pellet_view dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .p_row(p_row), .p_col(p_col),
    .color_valid(color_valid), .color_data(color_data),
    .eat_req(eat_req), .eat_row(eat_row), .eat_col(eat_col),
    .eat_ack(eat_ack), .eat_hit(eat_hit), .eat_power(eat_power),
    .refill(refill), .busy(busy), .pellets_left(pellets_left), .all_eaten(all_eaten)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit        started = 1'b0;
  bit        m_pel[64];
  bit        m_init = 1'b1;
  int        m_sweep = 0;
  bit        e_ack = 1'b0, e_hit = 1'b0;
  bit        s1_v = 1'b0, e_cv = 1'b0;
  int        s1_r = 0, s1_c = 0;
  logic [11:0] e_cd = 12'h000;

  function automatic logic [11:0] color_of(int r, int c, bit busy_now);
    int tr, tc, orr, oc, i;
    tr = r / 60; if (tr > 7) tr = 7;
    tc = c / 60; if (tc > 7) tc = 7;
    orr = r - tr * 60;
    oc  = c - tc * 60;
    i = tr * 8 + tc;
    if (!MAP[i]) return 12'h8AF;
    if (!busy_now && m_pel[i] && orr >= 26 && orr < 34 && oc >= 26 && oc < 34) return 12'hFFF;
    return 12'h000;
  endfunction

  function automatic int model_count();
    int n = 0;
    int lim = m_init ? m_sweep : 64;
    for (int i = 0; i < lim; i++) n += int'(m_pel[i]);
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1;
      m_init = 1'b1; m_sweep = 0;
      for (int i = 0; i < 64; i++) m_pel[i] = 1'b0;
      e_ack = 1'b0; e_hit = 1'b0; s1_v = 1'b0; e_cv = 1'b0;
    end else begin
      e_cv = s1_v;
      if (s1_v) e_cd = color_of(s1_r, s1_c, m_init);
      s1_v = pix_valid; s1_r = int'(p_row); s1_c = int'(p_col);
      e_ack = 1'b0; e_hit = 1'b0;
      if (refill) begin
        m_init = 1'b1; m_sweep = 0;
      end else if (m_init) begin
        m_pel[m_sweep] = MAP[m_sweep];
        m_sweep++;
        if (m_sweep == 64) m_init = 1'b0;
      end else if (eat_req) begin
        e_ack = 1'b1;
        if (eat_row < 10'd8 && eat_col < 10'd8 && m_pel[int'(eat_row) * 8 + int'(eat_col)]) begin
          m_pel[int'(eat_row) * 8 + int'(eat_col)] = 1'b0;
          e_hit = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy", {31'd0, busy}, {31'd0, m_init});
      check("pellets_left", {25'd0, pellets_left}, model_count());
      check("all_eaten", {31'd0, all_eaten}, {31'd0, (!m_init && model_count() == 0)});
      check("eat_ack", {31'd0, eat_ack}, {31'd0, e_ack});
      if (e_ack) begin
        check("eat_hit", {31'd0, eat_hit}, {31'd0, e_hit});
        check("eat_power", {31'd0, eat_power}, 32'd0);
      end
      check("color_valid", {31'd0, color_valid}, {31'd0, e_cv});
      if (e_cv) check("color_data", {20'd0, color_data}, {20'd0, e_cd});
    end
  end

  task automatic measure_busy(output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
  endtask

  task automatic pixel_lit(input string name, input int r, input int c, input logic [11:0] exp);
    @(posedge clk); #1;
    pix_valid = 1'b1; p_row = 10'(r); p_col = 10'(c);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, {31'd0, color_valid}, 32'd1);
    check(name, {20'd0, color_data}, {20'd0, exp});
  endtask

  task automatic eat_lit(input string name, input int r, input int c, input bit hit, input int left);
    @(posedge clk); #1;
    eat_req = 1'b1; eat_row = 10'(r); eat_col = 10'(c);
    @(posedge clk); #1;
    eat_req = 1'b0;
    @(negedge clk);
    check({name, "_ack"}, {31'd0, eat_ack}, 32'd1);
    check({name, "_hit"}, {31'd0, eat_hit}, {31'd0, hit});
    check({name, "_left"}, {25'd0, pellets_left}, left);
  endtask

  initial begin
    int n;
    int left;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    measure_busy(n);
    check("init_busy_cycles", n, 32'd64);
    check("init_left", {25'd0, pellets_left}, 32'd22);
    check("init_all_eaten", {31'd0, all_eaten}, 32'd0);

    pixel_lit("pix_0_0", 0, 0, 12'h8AF);
    pixel_lit("pix_90_30", 90, 30, 12'h8AF);
    pixel_lit("pix_90_90", 90, 90, 12'hFFF);
    pixel_lit("pix_61_61", 61, 61, 12'h000);

    eat_lit("eat_1_1", 1, 1, 1'b1, 21);
    pixel_lit("pix_90_90_eaten", 90, 90, 12'h000);
    eat_lit("eat_1_1_again", 1, 1, 1'b0, 21);
    eat_lit("eat_wall", 0, 0, 1'b0, 21);

    left = 21;
    for (int i = 0; i < 64; i++) begin
      if (MAP[i] && i != 9) begin
        left--;
        eat_lit("eat_all", i / 8, i % 8, 1'b1, left);
      end
    end
    check("all_eaten_set", {31'd0, all_eaten}, 32'd1);

    @(posedge clk); #1;
    refill = 1'b1; eat_req = 1'b1; eat_row = 10'd2; eat_col = 10'd2;
    @(posedge clk); #1;
    refill = 1'b0; eat_req = 1'b0;
    check("refill_eat_ack", {31'd0, eat_ack}, 32'd0);
    measure_busy(n);
    check("refill_busy_cycles", n, 32'd64);
    check("refill_left", {25'd0, pellets_left}, 32'd22);
    check("refill_all_eaten", {31'd0, all_eaten}, 32'd0);

    pixel_lit("pix_700_700", 700, 700, 12'h8AF);
    eat_lit("eat_9_2", 9, 2, 1'b0, 22);

    @(posedge clk); #1 refill = 1'b1;
    @(posedge clk); #1 refill = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    measure_busy(n);
    check("midinit_reset_busy_cycles", n, 32'd64);

    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      pix_valid = ($urandom_range(0, 1) == 1);
      p_row     = 10'($urandom_range(0, 1023));
      p_col     = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) begin
        p_row = 10'($urandom_range(0, 7) * 60 + $urandom_range(20, 40));
        p_col = 10'($urandom_range(0, 7) * 60 + $urandom_range(20, 40));
      end
      eat_req   = ($urandom_range(0, 3) == 0);
      eat_row   = 10'($urandom_range(0, 9));
      eat_col   = 10'($urandom_range(0, 9));
      refill    = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0; eat_req = 1'b0; refill = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/maze_pellet_view.md
Name: maze_pellet_view

Overview:
- Parametrised, pipelined maze renderer with live pellet state, successor to the fixed 8x8 combinational maze lookup.
- Maps a pixel (p_row, p_col) to a tile and returns wall, path or pellet colour two cycles later.
- Holds one pellet bit per tile, refilled by an init sweep; game logic clears pellets through an eat request/ack port and reads the remaining count.

Parameters:
- ROWS, 8, maze tile rows.
- COLS, 8, maze tile columns.
- TILE_PX, 60, tile edge in pixels.
- PELLET_PX, 8, pellet square edge in pixels (PELLET_PX <= TILE_PX).
- PATH_MAP, 64'h007E_4242_7E12_1E00, ROWS*COLS bits; bit r*COLS+c = 1 means tile (r,c) is path, 0 means wall.
- WALL_COLOR, 12'h8AF, RGB444 wall colour.
- PATH_COLOR, 12'h000, path colour.
- PELLET_COLOR, 12'hFFF, pellet colour.
- POWER_MAP, 64'h0040_0000_0000_0002, power-pellet tiles; used only with the macro.
- POWER_COLOR, 12'hFA0, power-pellet colour; used only with the macro.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- pix_valid  in  1  pixel request strobe
- p_row  in  10  pixel row, top-left is 0,0
- p_col  in  10  pixel column
- color_valid  out  1  pix_valid delayed 2 cycles
- color_data  out  12  RGB444 pixel colour
- eat_req  in  1  one-cycle eat request
- eat_row  in  10  tile row
- eat_col  in  10  tile column
- eat_ack  out  1  one-cycle acknowledge
- eat_hit  out  1  valid with eat_ack; a pellet was removed
- eat_power  out  1  valid with eat_ack; the removed pellet was a power pellet
- refill  in  1  one-cycle pulse; restart the init sweep
- busy  out  1  high during INIT
- pellets_left  out  $clog2(ROWS*COLS+1)  remaining pellets
- all_eaten  out  1  high when pellets_left==0 and not busy

Behaviour:
- Reset values: state INIT, busy=1, color_valid=0, color_data=0, eat_ack=0, eat_hit=0, eat_power=0, pellets_left=0, all_eaten=0. Pipeline valid bits are cleared.
- FSM has two states, INIT and IDLE.
- INIT:
  - Sweep index 0..ROWS*COLS-1, one tile per cycle.
  - Write pellet[i] = PATH_MAP[i] and add PATH_MAP[i] to pellets_left. The count is zeroed on entry.
  - Go to IDLE after the last index. Duration is exactly ROWS*COLS cycles, then busy=0.
- IDLE:
  - refill → INIT.
  - Reset or refill mid-sweep restarts the sweep from index 0.
- Eat (IDLE only):
  - eat_req in cycle N gives eat_ack=1 in cycle N+1.
  - If the tile is in range and its pellet bit is set: clear the bit, decrement pellets_left, eat_hit=1.
  - Otherwise eat_hit=0. This covers wall tiles, already-eaten tiles and out-of-range coordinates.
  - eat_req while busy is dropped: no ack.
  - refill and eat_req in the same cycle: refill wins; eat is dropped, no ack.
  - Back-to-back eat_req is accepted every cycle.
- Pixel pipeline (runs in every state):
  - Stage 1 registers tile r=p_row/TILE_PX, c=p_col/TILE_PX, each clamped to ROWS-1/COLS-1, plus offsets orow=p_row-r*TILE_PX and ocol=p_col-c*TILE_PX.
  - Offsets are computed on the clamped tile, so a clamped pixel gets an offset >= TILE_PX and no pellet.
  - Stage 2 registers color_data and color_valid. Latency is 2 cycles; throughput is 1 pixel per clock.
- Colour priority:
  1. Wall → WALL_COLOR.
  2. Path with pellet bit set, not busy, and both offsets in [(TILE_PX-PELLET_PX)/2, (TILE_PX-PELLET_PX)/2+PELLET_PX) → PELLET_COLOR.
  3. Otherwise → PATH_COLOR.
- The stage-2 pellet read sees the value before any eat write landing in the same cycle.
- pellets_left never underflows and never exceeds the popcount of PATH_MAP.

Optional Feature:
- Macro: POWER_PELLET_EN.
- Defined:
  - Path tiles with POWER_MAP bit set draw a pellet of edge 2*PELLET_PX, centred, in POWER_COLOR.
  - An eat that removes such a pellet also sets eat_power=1.
  - Power pellets count in pellets_left.
- Undefined: POWER_MAP and POWER_COLOR are ignored and eat_power is tied to 0.

Test Plan:
- Reset then idle for 64 cycles → busy falls after exactly 64 cycles; pellets_left=22; all_eaten=0.
- Pixel (0,0) and pixel (90,30) (tile 1,0) with pix_valid → two cycles later color_valid=1, color_data=12'h8AF for both.
- Pixel (90,90) (tile 1,1, offset 30,30) → 12'hFFF. Pixel (61,61) → 12'h000.
- eat (1,1) → ack next cycle, hit=1, pellets_left=21, pixel (90,90) then 12'h000. Repeat eat (1,1) → hit=0, count unchanged. eat (0,0) wall → hit=0.
- Eat all 22 path tiles → all_eaten=1. refill → busy=1 for 64 cycles, pellets_left=22, all_eaten=0. eat_req same cycle as refill → no ack.
- Pixel (700,700) → clamped to tile (7,7), 12'h8AF. eat (9,2) → hit=0. Reset mid-INIT at sweep index 30 → sweep restarts at 0, busy for 64 more cycles.
